// File: rtl/fpu_cmd_sequencer.sv
// fpu_cmd_sequencer: FIFO-buffered FPU command issue with opcode decode, watchdog and tagged completion.
module fpu_cmd_sequencer #(
  parameter int OPC_W   = 4,
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [OPC_W-1:0]         cmd_opcode,
  input  logic [TAG_W-1:0]         cmd_tag,
  output logic                     start_alu,
  output logic [1:0]               alu_control,
  input  logic                     alu_done,
  output logic                     done,
  output logic [TAG_W-1:0]         done_tag,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_e;
  state_e            state_q, state_d;
  logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [OPC_W-1:0]  op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [CW-1:0]     wd_q, wd_d;
  logic [1:0]        code_q, code_d;
  logic [OPC_W+TAG_W-1:0] mem_q [DEPTH];
  logic              push, pop, fin;
  logic [OPC_W-1:0]  head_op;
  assign cmd_ready = cnt_q != (AW+1)'(DEPTH);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = state_q == IDLE && cnt_q != '0;
  assign head_op   = mem_q[rd_q][OPC_W+TAG_W-1:TAG_W];
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {cmd_opcode, cmd_tag};
  end
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tag_d   = tag_q;
    wd_d    = wd_q;
    code_d  = code_q;
    wr_d    = push ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    case (state_q)
      IDLE: if (pop) begin
        op_d    = head_op;
        tag_d   = mem_q[rd_q][TAG_W-1:0];
        code_d  = head_op > OPC_W'(3) ? 2'b01 : 2'b00;
        state_d = head_op > OPC_W'(3) ? ERR : ISSUE;
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      // completion takes priority over a watchdog expiring in the same cycle
      WAIT: if (alu_done) begin
        code_d  = 2'b00;
        state_d = DONE;
      end else if (TIMEOUT != 0 && wd_q == CW'(TIMEOUT - 1)) begin
        code_d  = 2'b10;
        state_d = DONE;
      end else begin
        wd_d = wd_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      wd_q    <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      wd_q    <= wd_d;
      code_q  <= code_d;
    end
  end
  assign fin         = state_q == DONE || state_q == ERR;
  assign start_alu   = state_q == ISSUE;
  assign alu_control = (state_q == ISSUE || state_q == WAIT || state_q == DONE) ? op_q[1:0] : 2'b00;
  assign done        = fin;
  assign done_tag    = fin ? tag_q : '0;
  assign err         = fin && code_q != 2'b00;
  assign err_code    = fin ? code_q : 2'b00;
  assign busy        = state_q != IDLE || cnt_q != '0;
  assign fifo_count  = cnt_q;
endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// tb_fpu_cmd_sequencer: directed scoreboard bench for fpu_cmd_sequencer (DEPTH=4, TIMEOUT=8).
module tb_fpu_cmd_sequencer;
  typedef struct packed {
    logic [3:0] tag;
    logic [1:0] ctl;
    logic [1:0] code;
  } exp_t;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       cmd_valid = 0;
  logic       cmd_ready;
  logic [3:0] cmd_opcode = 0;
  logic [3:0] cmd_tag = 0;
  logic       start_alu;
  logic [1:0] alu_control;
  logic       alu_done = 0;
  logic       done;
  logic [3:0] done_tag;
  logic       err;
  logic [1:0] err_code;
  logic       busy;
  logic [2:0] fifo_count;
  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  bit         saw_start, saw_done;

  fpu_cmd_sequencer #(.OPC_W(4), .TAG_W(4), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_tag(cmd_tag), .start_alu(start_alu),
    .alu_control(alu_control), .alu_done(alu_done), .done(done), .done_tag(done_tag),
    .err(err), .err_code(err_code), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    if (start_alu) begin
      saw_start = 1;
      if (sb.size() == 0) chk("start_unexpected", start_alu, 0);
      else chk("start_ctl", {sb[0].code == 2'b01, alu_control}, {1'b0, sb[0].ctl});
    end
    if (done) begin
      saw_done = 1;
      if (sb.size() == 0) chk("done_unexpected", done, 0);
      else begin
        e = sb.pop_front();
        chk("done_tag", done_tag, e.tag);
        chk("done_err", err, e.code != 2'b00);
        chk("done_code", err_code, e.code);
      end
    end
  endtask

  task automatic push(input logic [3:0] op, input logic [3:0] tag, input bit tmo);
    exp_t e;
    e.tag  = tag;
    e.ctl  = op <= 4'd3 ? op[1:0] : 2'b00;
    e.code = op > 4'd3 ? 2'b01 : (tmo ? 2'b10 : 2'b00);
    cmd_valid  = 1;
    cmd_opcode = op;
    cmd_tag    = tag;
    if (cmd_ready) sb.push_back(e);
    step();
    cmd_valid = 0;
  endtask

  task automatic wait_start();
    saw_start = 0;
    for (int i = 0; i < 20 && !saw_start; i++) step();
    chk("start_seen", saw_start, 1);
  endtask

  task automatic run_one(input int d);
    wait_start();
    repeat (d) step();
    alu_done = 1;
    saw_done = 0;
    step();
    alu_done = 0;
    chk("done_seen", saw_done, 1);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_ready"}, cmd_ready, 1);
    chk({p, "_start"}, start_alu, 0);
    chk({p, "_ctl"}, alu_control, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_tag"}, done_tag, 0);
    chk({p, "_err"}, err, 0);
    chk({p, "_code"}, err_code, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_count"}, fifo_count, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst_n = 1;
    step();
    // single add, alu_done three cycles after start
    push(4'd0, 4'd5, 0);
    chk("t1_count", fifo_count, 1);
    chk("t1_nostart", start_alu, 0);
    step();
    chk("t1_start", start_alu, 1);
    chk("t1_ctl", alu_control, 2'b00);
    repeat (3) step();
    alu_done = 1;
    saw_done = 0;
    step();
    alu_done = 0;
    chk("t1_done", saw_done, 1);
    step();
    chk("t1_idle_done", done, 0);
    chk("t1_idle_busy", busy, 0);
    // back-to-back fill while the datapath stalls
    push(4'd3, 4'd1, 0);
    push(4'd2, 4'd2, 0);
    push(4'd1, 4'd3, 0);
    push(4'd0, 4'd4, 0);
    chk("t2_count3", fifo_count, 3);
    chk("t2_ready3", cmd_ready, 1);
    push(4'd0, 4'd5, 0);
    chk("t2_count4", fifo_count, 4);
    chk("t2_ready4", cmd_ready, 0);
    push(4'd2, 4'd6, 0);
    chk("t2_full_hold", fifo_count, 4);
    alu_done = 1;
    saw_done = 0;
    step();
    alu_done = 0;
    chk("t2_first_done", saw_done, 1);
    repeat (4) run_one(1);
    step();
    chk("t2_empty", fifo_count, 0);
    chk("t2_busy", busy, 0);
    // illegal opcode
    push(4'd7, 4'd9, 0);
    chk("t3_nostart", start_alu, 0);
    step();
    chk("t3_done", done, 1);
    chk("t3_code", err_code, 2'b01);
    chk("t3_tag", done_tag, 9);
    step();
    chk("t3_after", done, 0);
    // watchdog expiry then next queued command
    push(4'd2, 4'd6, 1);
    push(4'd1, 4'd7, 0);
    chk("t4_start", start_alu, 1);
    repeat (8) step();
    chk("t4_not_yet", done, 0);
    step();
    chk("t4_done", done, 1);
    chk("t4_code", err_code, 2'b10);
    run_one(2);
    step();
    // alu_done while idle is ignored
    alu_done = 1;
    repeat (2) step();
    alu_done = 0;
    chk("t5_idle_done", done, 0);
    chk("t5_idle_busy", busy, 0);
    // completion coinciding with the last watchdog cycle
    push(4'd3, 4'd8, 0);
    repeat (9) step();
    chk("t5_pre", done, 0);
    alu_done = 1;
    saw_done = 0;
    step();
    alu_done = 0;
    chk("t5_done", saw_done, 1);
    chk("t5_code", err_code, 2'b00);
    step();
    // asynchronous reset in WAIT with two queued
    push(4'd0, 4'd11, 0);
    push(4'd1, 4'd12, 0);
    push(4'd2, 4'd13, 0);
    chk("t6_count", fifo_count, 2);
    #2 rst_n = 0;
    #1 chk_reset("t6_async");
    sb.delete();
    repeat (2) step();
    rst_n = 1;
    saw_done = 0;
    repeat (2) step();
    chk("t6_no_done", saw_done, 0);
    chk("t6_count0", fifo_count, 0);
    chk("t6_busy", busy, 0);
    push(4'd1, 4'd14, 0);
    run_one(1);
    step();
    chk("t6_sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
